// File: rtl/wb_burst_master.sv
// Wishbone pipelined burst initiator: one command becomes a classic or wrapped
// burst of 1/4/8/16 beats, fed from a write FIFO and draining into a read FIFO.
`timescale 1ns/1ps
module wb_burst_master #(
  parameter int AW = 30,
  parameter int DW = 32
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_we,
  input  logic [AW-1:0] cmd_adr,
  input  logic [1:0]    cmd_len,
  input  logic [DW-1:0] wdat_i,
  input  logic          wdat_empty,
  output logic          wdat_re,
  output logic [DW-1:0] rdat_o,
  output logic          rdat_we,
  input  logic          rdat_room,
  output logic          cyc_o,
  output logic          stb_o,
  output logic          we_o,
  output logic [AW-1:0] adr_o,
  output logic [DW-1:0] dat_o,
  output logic [2:0]    cti_o,
  output logic [1:0]    bte_o,
  input  logic [DW-1:0] dat_i,
  input  logic          ack_i,
  input  logic          stall_i,
  output logic          busy,
  output logic [1:0]    state_dbg
);

  // Handshakes: a command transfers on cmd_valid & cmd_ready; a strobe is
  // taken on stb_o & !stall_i; every ack_i seen while busy completes one beat.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WR   = 2'd1,
    S_RD   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          we_q;
  logic [AW-1:0] adr_q;
  logic [1:0]    len_q;
  logic [4:0]    iss_q, ackc_q;
  logic [4:0]    n_beats, n_m1;
  logic [3:0]    lo_mask, adr_sum;
  logic          cmd_acc, strobe_acc, ack_cnt, last_ack;

  always_comb begin
    case (len_q)
      2'b00:   n_beats = 5'd1;
      2'b01:   n_beats = 5'd4;
      2'b10:   n_beats = 5'd8;
      default: n_beats = 5'd16;
    endcase
    n_m1    = n_beats - 5'd1;
    lo_mask = n_m1[3:0];
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    cyc_o     = busy;
    we_o      = we_q;
    cmd_ready = (state_q == S_IDLE) & (cmd_we | rdat_room);
    stb_o     = 1'b0;
    if (state_q == S_RD)
      stb_o = (iss_q < n_beats);
    else if (state_q == S_WR)
      stb_o = (iss_q < n_beats) & !wdat_empty;
    wdat_re    = stb_o & we_q & !stall_i;
    dat_o      = wdat_i;
    rdat_o     = dat_i;
    rdat_we    = (state_q == S_RD) & ack_i;
    cmd_acc    = cmd_valid & cmd_ready;
    strobe_acc = stb_o & !stall_i;
    ack_cnt    = busy & ack_i;
    last_ack   = ack_cnt & (ackc_q == n_m1);
    state_dbg  = state_q;
  end

  // The wrap adds only within the low log2(N) bits; upper bits never see a carry.
  always_comb begin
    adr_sum = adr_q[3:0] + iss_q[3:0];
    adr_o   = '0;
    cti_o   = 3'b000;
    bte_o   = 2'b00;
    if (busy) begin
      adr_o = (adr_q & ~{{(AW-4){1'b0}}, lo_mask}) |
              {{(AW-4){1'b0}}, adr_sum & lo_mask};
      bte_o = len_q;
      if (len_q == 2'b00)
        cti_o = 3'b000;
      else if (iss_q == n_m1)
        cti_o = 3'b111;
      else
        cti_o = 3'b010;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid & cmd_we)
          state_d = S_WR;
        else if (cmd_valid & rdat_room)
          state_d = S_RD;
      end
      S_WR, S_RD: begin
        if (last_ack)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      len_q   <= 2'b00;
      iss_q   <= 5'd0;
      ackc_q  <= 5'd0;
    end else begin
      state_q <= state_d;
      if (cmd_acc) begin
        we_q   <= cmd_we;
        adr_q  <= cmd_adr;
        len_q  <= cmd_len;
        iss_q  <= 5'd0;
        ackc_q <= 5'd0;
      end else begin
        if (strobe_acc)
          iss_q <= iss_q + 5'd1;
        if (ack_cnt)
          ackc_q <= ackc_q + 5'd1;
      end
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Bench for wb_burst_master: directed bursts against a queue-based burst model
// checked every cycle, plus literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_wb_burst_master;
  localparam int AW = 30;
  localparam int DW = 32;

  logic          wb_clk = 1'b0;
  logic          wb_rst = 1'b0;
  logic          cmd_valid = 1'b0, cmd_we = 1'b0;
  logic [AW-1:0] cmd_adr = '0;
  logic [1:0]    cmd_len = 2'b00;
  logic          cmd_ready;
  logic [DW-1:0] wdat_i, rdat_o, dat_o, dat_i;
  logic          wdat_empty, wdat_re, rdat_we;
  logic          rdat_room = 1'b1;
  logic          cyc_o, stb_o, we_o, busy;
  logic [AW-1:0] adr_o;
  logic [2:0]    cti_o;
  logic [1:0]    bte_o, state_dbg;
  logic          ack_i, stall_i = 1'b0;

  logic          ack_auto = 1'b1, ack_man = 1'b0, force_empty = 1'b0, flush_req = 1'b0;
  logic          chk_en = 1'b0;
  logic [DW-1:0] fifo_mem [0:63];
  int            rd_ptr = 0, wr_ptr = 0;
  logic [31:0]   cyc_n = 0;

  int n_checks = 0, n_fail = 0;

  always #5 wb_clk = ~wb_clk;

  assign wdat_i     = fifo_mem[rd_ptr[5:0]];
  assign wdat_empty = (rd_ptr == wr_ptr) | force_empty;
  assign ack_i      = ack_auto ? (stb_o & !stall_i) : ack_man;
  assign dat_i      = {16'hDA7A, cyc_n[15:0]};

  always @(posedge wb_clk) begin
    cyc_n <= cyc_n + 32'd1;
    if (flush_req) rd_ptr <= wr_ptr;
    else if (wdat_re) rd_ptr <= rd_ptr + 1;
  end

  wb_burst_master #(.AW(AW), .DW(DW)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_adr(cmd_adr), .cmd_len(cmd_len),
    .wdat_i(wdat_i), .wdat_empty(wdat_empty), .wdat_re(wdat_re),
    .rdat_o(rdat_o), .rdat_we(rdat_we), .rdat_room(rdat_room),
    .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o),
    .dat_o(dat_o), .cti_o(cti_o), .bte_o(bte_o),
    .dat_i(dat_i), .ack_i(ack_i), .stall_i(stall_i),
    .busy(busy), .state_dbg(state_dbg)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Burst model: a burst is a list of expected beat addresses/cycle types plus
  // a count of acks still owed; nothing here looks at the DUT's internals.
  logic          m_busy = 1'b0, m_we = 1'b0;
  logic [1:0]    m_bte = 2'b00;
  int            m_acks_left = 0;
  logic [AW-1:0] m_adr_q[$];
  logic [2:0]    m_cti_q[$];
  logic [DW-1:0] exp_q[$];

  // Observations for the literal checks (indices are taken as baselines).
  logic [AW-1:0] cap_adr[$];
  logic [2:0]    cap_cti[$];
  logic [1:0]    cap_bte[$];
  logic [DW-1:0] cap_dat[$];
  logic          cap_we[$];
  int pops = 0, pushes = 0, cyc_hi = 0, nostb = 0, gap_cur = 0, last_gap = -1;
  logic prev_cyc = 1'b0, seen_cyc = 1'b0;

  always @(negedge wb_clk) begin
    logic exp_stb;
    int n, lo;
    if (chk_en) begin
      exp_stb = m_busy && (m_adr_q.size() > 0) && (!m_we || !wdat_empty);
      chk("busy", busy, m_busy);
      chk("cyc_o", cyc_o, m_busy);
      chk("stb_o", stb_o, exp_stb);
      chk("wdat_re", wdat_re, exp_stb && m_we && !stall_i);
      chk("rdat_we", rdat_we, m_busy && !m_we && ack_i);
      chk("cmd_ready", cmd_ready, !m_busy && (cmd_we || rdat_room));
      if (m_busy) begin
        chk("we_o", we_o, m_we);
        chk("bte_o", bte_o, m_bte);
      end
      if (exp_stb) begin
        chk("adr_o", adr_o, m_adr_q[0]);
        chk("cti_o", cti_o, m_cti_q[0]);
        if (m_we) chk("dat_o", dat_o, wdat_i);
      end
      if (m_busy && !m_we && ack_i) exp_q.push_back(dat_i);
      if (rdat_we && exp_q.size() > 0) chk("rdat_o", rdat_o, exp_q.pop_front());

      if (stb_o && !stall_i) begin
        cap_adr.push_back(adr_o); cap_cti.push_back(cti_o);
        cap_bte.push_back(bte_o); cap_dat.push_back(dat_o);
      end
      if (wdat_re) pops++;
      if (rdat_we) pushes++;
      if (cyc_o) cyc_hi++;
      if (cyc_o && !stb_o) nostb++;
      if (cyc_o && !prev_cyc) begin
        cap_we.push_back(we_o);
        if (seen_cyc) last_gap = gap_cur;
        seen_cyc = 1'b1;
      end
      if (!cyc_o) gap_cur++; else gap_cur = 0;
      prev_cyc = cyc_o;

      if (!wb_rst) begin
        m_busy = 1'b0; m_adr_q.delete(); m_cti_q.delete(); exp_q.delete();
      end else if (m_busy) begin
        if (exp_stb && !stall_i) begin
          void'(m_adr_q.pop_front()); void'(m_cti_q.pop_front());
        end
        if (ack_i) begin
          m_acks_left--;
          if (m_acks_left == 0) m_busy = 1'b0;
        end
      end else if (cmd_valid && (cmd_we || rdat_room)) begin
        n = (cmd_len == 2'b00) ? 1 : (cmd_len == 2'b01) ? 4 : (cmd_len == 2'b10) ? 8 : 16;
        lo = int'(cmd_adr) % n;
        for (int k = 0; k < n; k++) begin
          m_adr_q.push_back(cmd_adr - AW'(lo) + AW'((lo + k) % n));
          m_cti_q.push_back((n == 1) ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010);
        end
        m_bte = (n == 1) ? 2'b00 : (n == 4) ? 2'b01 : (n == 8) ? 2'b10 : 2'b11;
        m_we = cmd_we; m_acks_left = n; m_busy = 1'b1;
      end
    end
  end

  task automatic push_w(input logic [DW-1:0] v);
    fifo_mem[wr_ptr[5:0]] = v;
    wr_ptr++;
  endtask

  task automatic cycle1();
    @(posedge wb_clk); #1;
  endtask

  task automatic send_cmd(input logic we, input logic [AW-1:0] adr, input logic [1:0] len);
    logic got = 1'b0;
    cmd_we = we; cmd_adr = adr; cmd_len = len; cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge wb_clk);
      if (cmd_ready) begin got = 1'b1; break; end
    end
    @(posedge wb_clk); #1;
    cmd_valid = 1'b0;
    if (!got) chk("cmd_accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    logic done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      cycle1();
      if (!busy) begin done = 1'b1; break; end
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  initial begin
    int b, p0, q0, c0, s0, w0, n7;
    repeat (3) @(posedge wb_clk);
    #1;
    chk_en = 1'b1;
    chk("rst_cyc", cyc_o, 0); chk("rst_stb", stb_o, 0); chk("rst_busy", busy, 0);
    chk("rst_adr", adr_o, 0); chk("rst_cti", cti_o, 0); chk("rst_bte", bte_o, 0);
    wb_rst = 1'b1;
    cycle1();

    // Single write.
    push_w(32'hA5A5A5A5);
    b = cap_adr.size(); p0 = pops; c0 = cyc_hi;
    send_cmd(1'b1, 30'h100, 2'b00);
    wait_idle();
    chk("w1_beats", cap_adr.size() - b, 1);
    chk("w1_adr", cap_adr[b], 30'h100);
    chk("w1_cti", cap_cti[b], 3'b000);
    chk("w1_bte", cap_bte[b], 2'b00);
    chk("w1_dat", cap_dat[b], 32'hA5A5A5A5);
    chk("w1_pops", pops - p0, 1);
    chk("w1_cyc_cycles", cyc_hi - c0, 1);
    cycle1();

    // 4-beat read with a 3-cycle stall on the second beat.
    b = cap_adr.size(); q0 = pushes;
    send_cmd(1'b0, 30'h1E, 2'b01);
    stall_i = 1'b1;
    repeat (3) cycle1();
    stall_i = 1'b0;
    wait_idle();
    chk("r4_beats", cap_adr.size() - b, 4);
    chk("r4_adr0", cap_adr[b], 30'h1E);   chk("r4_adr1", cap_adr[b+1], 30'h1F);
    chk("r4_adr2", cap_adr[b+2], 30'h1C); chk("r4_adr3", cap_adr[b+3], 30'h1D);
    chk("r4_cti0", cap_cti[b], 3'b010);   chk("r4_cti2", cap_cti[b+2], 3'b010);
    chk("r4_cti3", cap_cti[b+3], 3'b111); chk("r4_bte", cap_bte[b], 2'b01);
    chk("r4_pushes", pushes - q0, 4);
    cycle1();

    // 8-beat write with a 2-cycle FIFO gap after beat 3.
    for (int i = 0; i < 8; i++) push_w(32'hC0DE0000 + DW'(i));
    b = cap_adr.size(); p0 = pops; s0 = nostb;
    send_cmd(1'b1, 30'h3FD, 2'b10);
    cycle1(); cycle1(); cycle1();
    force_empty = 1'b1;
    cycle1(); cycle1();
    force_empty = 1'b0;
    wait_idle();
    chk("w8_pops", pops - p0, 8);
    chk("w8_gap_cycles", nostb - s0, 2);
    n7 = 0;
    for (int i = b; i < cap_cti.size(); i++) if (cap_cti[i] == 3'b111) n7++;
    chk("w8_cti_last_count", n7, 1);
    chk("w8_cti_beat8", cap_cti[b+7], 3'b111);
    chk("w8_adr_beat4", cap_adr[b+3], 30'h3F8);
    chk("w8_dat_beat8", cap_dat[b+7], 32'hC0DE0007);
    cycle1();

    // 16-beat read held off by rdat_room.
    cmd_we = 1'b0; cmd_adr = 30'h2A5; cmd_len = 2'b11; cmd_valid = 1'b1; rdat_room = 1'b0;
    repeat (3) begin
      @(negedge wb_clk);
      chk("r16_noroom_ready", cmd_ready, 0);
      chk("r16_noroom_cyc", cyc_o, 0);
    end
    cycle1();
    rdat_room = 1'b1;
    b = cap_adr.size(); q0 = pushes;
    send_cmd(1'b0, 30'h2A5, 2'b11);
    wait_idle();
    chk("r16_beats", cap_adr.size() - b, 16);
    chk("r16_adr0", cap_adr[b], 30'h2A5);
    chk("r16_adr10", cap_adr[b+10], 30'h2AF);
    chk("r16_adr11", cap_adr[b+11], 30'h2A0);
    chk("r16_adr15", cap_adr[b+15], 30'h2A4);
    chk("r16_bte", cap_bte[b+5], 2'b11);
    chk("r16_pushes", pushes - q0, 16);
    cycle1();

    // Reset in the middle of a 16-beat write.
    for (int i = 0; i < 16; i++) push_w(32'hBEEF0000 + DW'(i));
    p0 = pops; q0 = pushes;
    send_cmd(1'b1, 30'h500, 2'b11);
    for (int i = 0; i < 50 && (pops - p0) < 4; i++) cycle1();
    wb_rst = 1'b0;
    cycle1();
    chk("rst_mid_cyc", cyc_o, 0);
    chk("rst_mid_stb", stb_o, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_pops", pops - p0, 5);
    wb_rst = 1'b1;
    ack_auto = 1'b0; ack_man = 1'b1;
    repeat (3) cycle1();
    ack_man = 1'b0; ack_auto = 1'b1;
    cycle1();
    chk("rst_post_pops", pops - p0, 5);
    chk("rst_post_pushes", pushes - q0, 0);
    flush_req = 1'b1;
    cycle1();
    flush_req = 1'b0;
    cycle1();

    // Back-to-back: 4-beat write then single read queued behind it.
    for (int i = 0; i < 4; i++) push_w(32'h11110000 + DW'(i));
    w0 = cap_we.size();
    send_cmd(1'b1, 30'h40, 2'b01);
    send_cmd(1'b0, 30'h80, 2'b00);
    wait_idle();
    chk("b2b_gap", last_gap, 1);
    chk("b2b_bursts", cap_we.size() - w0, 2);
    chk("b2b_we_first", cap_we[w0], 1);
    chk("b2b_we_second", cap_we[w0+1], 0);
    cycle1(); cycle1();
    chk("end_rdat_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_burst_master.md
# wb_burst_master

Wishbone pipelined burst initiator for the memory-controller side of the Wishbone bridge. Takes one command per transfer from a command interface, issues a classic or wrapped burst (1, 4, 8 or 16 beats) toward a Wishbone slave, sources write data from a first-word-fall-through write-data FIFO, and pushes returned read data into a read-data FIFO. It drives the same `cyc`, `stb`, `we`, `cti`, `bte`, `stall` and `ack` semantics that the slave-side FSM consumes.

## Interface
Parameters:
- `AW`, 30, word-address width.
- `DW`, 32, data width.

Ports:
- `wb_clk` in 1: sole clock.
- `wb_rst` in 1: reset, synchronous, active-low (`0` = reset).
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: command accepted when `cmd_valid & cmd_ready`.
- `cmd_we` in 1: `1` = write burst, `0` = read burst.
- `cmd_adr` in AW: start word address.
- `cmd_len` in 2: burst length; `00`=1, `01`=4, `10`=8, `11`=16.
- `wdat_i` in DW: head of write FIFO.
- `wdat_empty` in 1: write FIFO empty.
- `wdat_re` out 1: write FIFO pop.
- `rdat_o` out DW: read data to FIFO.
- `rdat_we` out 1: read FIFO push.
- `rdat_room` in 1: read FIFO has at least 16 free entries.
- `cyc_o`, `stb_o`, `we_o` out 1: Wishbone cycle, strobe and write-enable.
- `adr_o` out AW: Wishbone address.
- `dat_o` out DW: Wishbone write data.
- `cti_o` out 3: cycle type.
- `bte_o` out 2: burst type.
- `dat_i` in DW: Wishbone read data.
- `ack_i` in 1: beat acknowledge.
- `stall_i` in 1: slave not accepting the current strobe.
- `busy` out 1: state not IDLE.

## Operation
- State machine with states IDLE, WR, RD:
  - IDLE -> WR on `cmd_valid & cmd_we`.
  - IDLE -> RD on `cmd_valid & !cmd_we & rdat_room`.
  - WR/RD -> IDLE on the cycle the final ack is received.
- `cmd_ready = (state==IDLE) & (cmd_we | rdat_room)`. On acceptance, `cmd_adr`, `cmd_len` and `cmd_we` are latched. `we_o` equals the latched `cmd_we`.
- Beat count N = 1, 4, 8 or 16. 5-bit counters `iss` (strobes accepted) and `ackc` (acks received) are cleared on acceptance.
- `cyc_o = busy`.
- `stb_o`:
  - RD: `iss < N`.
  - WR: `(iss < N) & !wdat_empty`.
  - A write data gap deasserts `stb_o` while `cyc_o` is held; this is a wait state, not an abort.
- A strobe is accepted when `stb_o & !stall_i`, which increments `iss`.
- `wdat_re = stb_o & we_o & !stall_i`.
- `dat_o = wdat_i`.
- `ack_i` is counted only while `busy`. Each counted ack increments `ackc`.
  - In RD, each counted ack pulses `rdat_we` and sets `rdat_o = dat_i` in the same cycle.
  - Acks outside `busy` are ignored.
- Address for beat k (k = `iss`):
  - The low log2(N) bits are `(adr_start_low + k) mod N`; the upper bits are unchanged.
  - N=1 gives `adr_start`.
  - The wrap is computed with width-limited adds, with no carry into the upper bits.
- `bte_o`: N=1 gives `00` (linear), 4 gives `01`, 8 gives `10`, 16 gives `11`.
- `cti_o`:
  - N=1 gives `000` (classic).
  - Otherwise `111` when `iss == N-1`, else `010` (incrementing).
- `busy`, `cti_o` and `bte_o` hold their values across stalls.
- Completion: when `ackc` reaches N, the state returns to IDLE.
- Outputs outside `busy`: `stb_o`, `wdat_re` and `rdat_we` are 0. `adr_o`, `cti_o` and `bte_o` are don't-care but must be stable.

## Timing
- Reset (`wb_rst == 0` at a clock edge): state is IDLE; `iss`, `ackc`, `cyc_o`, `stb_o`, `wdat_re`, `rdat_we` and `busy` are 0; `cti_o` is `000`, `bte_o` is `00`, `adr_o` is 0.
- Reset mid-burst drops `cyc_o` on the next edge. Outstanding acks are discarded and no FIFO pops or pushes occur after reset.
- Command accepted at edge T. `cyc_o` and the first possible `stb_o` are asserted after T, in cycle T+1.
- Pipelined strobes: with `stall_i=0` and data available, one beat is accepted per cycle. N beats are issued in N cycles (T+1 .. T+N).
- Acks may arrive in the same cycle as their strobe, or later. The block never issues more than N strobes and never counts more than N acks.
- Final ack at edge E: state is IDLE after E. `cyc_o=0` and `cmd_ready=1` in cycle E+1.
- A new command accepted at E+1 puts `cyc_o` high in E+2. There is exactly one idle cycle between bursts.
- Simultaneous events:
  - An ack and a strobe acceptance in the same cycle update both counters.
  - `stall_i` with `wdat_empty` in the same cycle pops nothing.
- `rdat_room` is sampled only in IDLE. It is not re-checked during RD.

## Test plan
- Single write (`cmd_len=00`, adr `0x100`, FIFO holds `0xA5A5A5A5`, `stall_i=0`, ack in the same cycle as strobe): one strobe with `cti_o=000`, `bte_o=00`, `adr_o=0x100`, `dat_o=0xA5A5A5A5`; one `wdat_re` pulse; `cyc_o` high for exactly 1 cycle; `busy=0` on the next cycle.
- 4-beat read at adr `0x1E` with `stall_i` high on the 2nd beat for 3 cycles: `adr_o` sequence `0x1E, 0x1F, 0x1C, 0x1D`; `cti_o` is `010,010,010,111`; `bte_o=01`; exactly 4 `rdat_we` pulses carrying `dat_i` in ack order.
- 8-beat write with `wdat_empty` high for 2 cycles after beat 3: `stb_o` low for those 2 cycles while `cyc_o` stays high; 8 pops total; `cti_o=111` only on beat 8.
- 16-beat read requested with `rdat_room=0`: `cmd_ready=0` and `cyc_o` stays low. Raise `rdat_room`: accepted; 16 strobes with `bte_o=11`; addresses wrap mod 16.
- Reset asserted (`wb_rst=0`) after 5 of 16 write beats: `cyc_o` and `stb_o` are 0 on the next edge; `busy=0`; further acks produce no FIFO activity.
- Back-to-back: write (N=4) then read (N=1) queued: exactly one cycle with `cyc_o=0` between bursts, and `we_o` flips at the start of the second burst.
